// File: rtl/video_sync_receiver.sv
// Sync receiver: rebuilds source x/y counters from hsync/vsync,
// checks every sync edge and emits locked per-pixel coordinates.
module video_sync_receiver #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         hsync,
  input  logic                         vsync,
  input  logic [3:0]                   r,
  input  logic [3:0]                   g,
  input  logic [3:0]                   b,
  output logic                         pixel_valid,
  output logic [$clog2(H_VISIBLE)-1:0] position_x,
  output logic [$clog2(V_VISIBLE)-1:0] position_y,
  output logic [3:0]                   r_out,
  output logic [3:0]                   g_out,
  output logic [3:0]                   b_out,
  output logic                         frame_start,
  output logic                         locked,
  output logic [15:0]                  error_count,
  output logic [31:0]                  frame_count
);

  localparam int WHOLE_LINE  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int WHOLE_FRAME = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START    = H_VISIBLE + H_FRONT;
  localparam int HS_END      = HS_START + H_SYNC;
  localparam int VS_START    = V_VISIBLE + V_FRONT;
  localparam int VS_END      = VS_START + V_SYNC;

  localparam int XW  = $clog2(WHOLE_LINE);
  localparam int YW  = $clog2(WHOLE_FRAME);
  localparam int PXW = $clog2(H_VISIBLE);
  localparam int PYW = $clog2(V_VISIBLE);

  localparam logic [XW-1:0] X_LAST  = XW'(WHOLE_LINE - 1);
  localparam logic [XW-1:0] X_HSS   = XW'(HS_START);
  localparam logic [XW-1:0] X_HSE   = XW'(HS_END);
  localparam logic [XW-1:0] X_VIS   = XW'(H_VISIBLE);
  localparam logic [YW-1:0] Y_LAST  = YW'(WHOLE_FRAME - 1);
  localparam logic [YW-1:0] Y_VSS   = YW'(VS_START);
  localparam logic [YW-1:0] Y_VSE   = YW'(VS_END);
  localparam logic [YW-1:0] Y_VIS   = YW'(V_VISIBLE);

  logic          hs_q, vs_q, hs_prev_q, vs_prev_q;
  logic [3:0]    r_q, g_q, b_q;
  logic [XW-1:0] x_q, x_d, x_e;
  logic [YW-1:0] y_q, y_d, y_e;
  logic          h_al_q, h_al_d, v_al_q, v_al_d;
  logic [1:0]    good_vs_q, good_vs_d;
  logic          locked_d;
  logic [15:0]   err_cnt_d;
  logic [31:0]   frame_cnt_d;
  logic          hs_fall, hs_rise, vs_fall, vs_rise;
  logic          x_wrap, x_at0, err;
  logic          valid_d, fstart_d;

  // Stage 1: register raw sync and colour; keep previous sync for edges
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      hs_prev_q <= hs_q;
      vs_prev_q <= vs_q;
      hs_q      <= hsync;
      vs_q      <= vsync;
      r_q       <= r;
      g_q       <= g;
      b_q       <= b;
    end
  end

  // Edge checks, counter prediction/snap and lock bookkeeping
  always_comb begin
    hs_fall = hs_prev_q & ~hs_q;
    hs_rise = ~hs_prev_q & hs_q;
    vs_fall = vs_prev_q & ~vs_q;
    vs_rise = ~vs_prev_q & vs_q;

    x_e    = hs_fall ? X_HSS : x_q;
    y_e    = vs_fall ? Y_VSS : y_q;
    x_at0  = (x_e == '0);
    x_wrap = (x_e == X_LAST);

    err = 1'b0;
    if (h_al_q) begin
      if (hs_fall && x_q != X_HSS) err = 1'b1;
      if (!hs_fall && x_q == X_HSS) err = 1'b1;
      if (hs_rise && x_q != X_HSE) err = 1'b1;
    end
    if (v_al_q) begin
      if (vs_fall && (y_q != Y_VSS || !x_at0)) err = 1'b1;
      if (!vs_fall && x_at0 && y_q == Y_VSS) err = 1'b1;
      if (vs_rise && (y_q != Y_VSE || !x_at0)) err = 1'b1;
    end

    x_d = x_wrap ? '0 : x_e + XW'(1);
    y_d = y_e;
    if (x_wrap) y_d = (y_e == Y_LAST) ? '0 : y_e + YW'(1);

    h_al_d = h_al_q | hs_fall;
    v_al_d = v_al_q | vs_fall;

    good_vs_d = good_vs_q;
    if (err) good_vs_d = 2'd0;
    else if (vs_fall && good_vs_q != 2'd3) good_vs_d = good_vs_q + 2'd1;
    locked_d = good_vs_d[1];

    err_cnt_d = error_count;
    if (err && error_count != 16'hFFFF) err_cnt_d = error_count + 16'd1;

    frame_cnt_d = frame_count;
    if (locked_d && x_wrap && y_e == Y_LAST) frame_cnt_d = frame_count + 32'd1;

    valid_d  = locked_d & (x_e < X_VIS) & (y_e < Y_VIS);
    fstart_d = valid_d & x_at0 & (y_e == '0);
  end

  // Tracking state and stage-2 registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      h_al_q      <= 1'b0;
      v_al_q      <= 1'b0;
      good_vs_q   <= 2'd0;
      locked      <= 1'b0;
      error_count <= '0;
      frame_count <= '0;
      pixel_valid <= 1'b0;
      position_x  <= '0;
      position_y  <= '0;
      r_out       <= '0;
      g_out       <= '0;
      b_out       <= '0;
      frame_start <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      h_al_q      <= h_al_d;
      v_al_q      <= v_al_d;
      good_vs_q   <= good_vs_d;
      locked      <= locked_d;
      error_count <= err_cnt_d;
      frame_count <= frame_cnt_d;
      pixel_valid <= valid_d;
      position_x  <= x_e[PXW-1:0];
      position_y  <= y_e[PYW-1:0];
      r_out       <= valid_d ? r_q : 4'd0;
      g_out       <= valid_d ? g_q : 4'd0;
      b_out       <= valid_d ? b_q : 4'd0;
      frame_start <= fstart_d;
    end
  end

endmodule

// File: tb/tb_video_sync_receiver.sv
// Bench for video_sync_receiver: small-timing source model,
// directed scenarios with hand-derived expectations.
module tb_video_sync_receiver;

  localparam int HV = 8, HF = 2, HS = 3, HB = 3;
  localparam int VV = 4, VF = 1, VS = 2, VB = 2;
  localparam int LINE = 16, FRAME = 9;
  localparam int HSS = 10, HSE = 13, VSS = 5, VSE = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [3:0]  r = '0, g = '0, b = '0;
  logic        pixel_valid;
  logic [2:0]  position_x;
  logic [1:0]  position_y;
  logic [3:0]  r_out, g_out, b_out;
  logic        frame_start;
  logic        locked;
  logic [15:0] error_count;
  logic [31:0] frame_count;

  video_sync_receiver #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .r(r), .g(g), .b(b),
    .pixel_valid(pixel_valid),
    .position_x(position_x), .position_y(position_y),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .frame_start(frame_start), .locked(locked),
    .error_count(error_count), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  bit gen_on = 0;
  int gx = 0, gy = 0;
  int hs_ovr = -1, vs_ovr = -1;
  bit skip_arm = 0, tag_next = 0;
  int cx = -1, cy = -1;
  bit ctag = 0;
  int ex = -1, ey = -1;
  logic [3:0] er, eg, eb;
  bit etag = 0;

  // one source sample per call; afterwards outputs show the previous sample
  task automatic cyc();
    ex = cx; ey = cy; er = r; eg = g; eb = b; etag = ctag;
    if (gen_on) begin
      hsync = (hs_ovr >= 0) ? hs_ovr[0] : !(gx >= HSS && gx < HSE);
      vsync = (vs_ovr >= 0) ? vs_ovr[0] : !(gy >= VSS && gy < VSE);
      r = 4'(gx);
      g = 4'(gy + 1);
      b = 4'(gx + 2 * gy + 3);
      cx = gx; cy = gy; ctag = tag_next; tag_next = 0;
      gx++;
      if (skip_arm && gx == HSS - 1) begin
        gx = HSS; skip_arm = 0; tag_next = 1;
      end
      if (gx == LINE) begin
        gx = 0; gy = (gy + 1) % FRAME;
      end
    end else begin
      hsync = 1'b1; vsync = 1'b1;
      r = '0; g = '0; b = '0;
      cx = -1; cy = -1; ctag = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // run until the second vsync falling edge reaches the outputs
  task automatic wait_relock(output int bad, output int occ);
    bad = 0; occ = 0;
    for (int i = 0; i < 500 && occ < 2; i++) begin
      cyc();
      if (ex == 0 && ey == VSS) occ++;
      if (locked !== (occ >= 2)) bad++;
      if (occ < 2 && pixel_valid !== 1'b0) bad++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; gen_on = 0;
    repeat (3) cyc();
    tests++; if (pixel_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", pixel_valid); end
    tests++; if (position_x !== 3'd0 || position_y !== 2'd0) begin fails++; $display("FAIL rst_pos: got %0d,%0d want 0,0", position_x, position_y); end
    tests++; if ({r_out, g_out, b_out} !== 12'd0) begin fails++; $display("FAIL rst_rgb: got %h want 0", {r_out, g_out, b_out}); end
    tests++; if (frame_start !== 1'b0 || locked !== 1'b0) begin fails++; $display("FAIL rst_flags: got fs=%b lk=%b want 0", frame_start, locked); end
    tests++; if (error_count !== 16'd0 || frame_count !== 32'd0) begin fails++; $display("FAIL rst_counts: got %0d,%0d want 0,0", error_count, frame_count); end
    rst = 1'b0;
    repeat (2000) cyc();
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL idle_locked: got %b want 0", locked); end
    tests++; if (error_count !== 16'd0) begin fails++; $display("FAIL idle_errors: got %0d want 0", error_count); end
  endtask

  task automatic test_lock();
    int bad, occ;
    gen_on = 1; gx = 0; gy = 0;
    wait_relock(bad, occ);
    tests++; if (bad != 0 || occ != 2) begin fails++; $display("FAIL lock_timing: got bad=%0d occ=%0d want 0,2", bad, occ); end
    tests++; if (error_count !== 16'd0) begin fails++; $display("FAIL lock_errors: got %0d want 0", error_count); end
    tests++; if (frame_count !== 32'd0) begin fails++; $display("FAIL lock_frames: got %0d want 0", frame_count); end
  endtask

  task automatic test_frames();
    int bad = 0, nval = 0, nfs = 0;
    bit ev;
    for (int i = 0; i < 3 * FRAME * LINE; i++) begin
      cyc();
      ev = (ex < HV) && (ey < VV);
      if (pixel_valid !== ev || locked !== 1'b1) bad++;
      if (ev) begin
        nval++;
        if (position_x !== 3'(ex) || position_y !== 2'(ey)) bad++;
        if (r_out !== er || g_out !== eg || b_out !== eb) bad++;
      end else if ({r_out, g_out, b_out} !== 12'd0) bad++;
      if (frame_start !== (ev && ex == 0 && ey == 0)) bad++;
      if (frame_start === 1'b1) nfs++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL frame_pixels: got %0d bad cycles want 0", bad); end
    tests++; if (nval != 96) begin fails++; $display("FAIL frame_valid_cnt: got %0d want 96", nval); end
    tests++; if (nfs != 3) begin fails++; $display("FAIL frame_start_cnt: got %0d want 3", nfs); end
    tests++; if (frame_count !== 32'd3) begin fails++; $display("FAIL frame_count: got %0d want 3", frame_count); end
    tests++; if (error_count !== 16'd0) begin fails++; $display("FAIL frame_errors: got %0d want 0", error_count); end
  endtask

  task automatic test_hs_early();
    int bad, occ;
    bit seen = 0;
    logic pl = 1'b0;
    skip_arm = 1;
    for (int i = 0; i < 40 && !seen; i++) begin
      pl = locked;
      cyc();
      if (etag) seen = 1;
    end
    tests++; if (!seen) begin fails++; $display("FAIL early_seen: got 0 want 1"); end
    tests++; if (pl !== 1'b1 || locked !== 1'b0) begin fails++; $display("FAIL early_lockdrop: got %b->%b want 1->0", pl, locked); end
    tests++; if (error_count !== 16'd1) begin fails++; $display("FAIL early_errors: got %0d want 1", error_count); end
    wait_relock(bad, occ);
    tests++; if (bad != 0 || occ != 2) begin fails++; $display("FAIL early_relock: got bad=%0d occ=%0d want 0,2", bad, occ); end
    tests++; if (error_count !== 16'd1) begin fails++; $display("FAIL early_errors2: got %0d want 1", error_count); end
    bad = 0;
    repeat (2 * LINE) begin
      cyc();
      if (pixel_valid && (position_x !== 3'(ex) || position_y !== 2'(ey))) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL early_positions: got %0d bad want 0", bad); end
  endtask

  task automatic test_hs_missing();
    int bad, occ;
    bit seen = 0;
    logic [15:0] pe = '0;
    for (int i = 0; i < LINE && gx != 0; i++) cyc();
    hs_ovr = 1;
    for (int i = 0; i < LINE + 3; i++) begin
      if (i == LINE) hs_ovr = -1;
      if (hs_ovr >= 0 && gx == HSS) tag_next = 1;
      pe = error_count;
      cyc();
      if (etag) begin
        seen = 1;
        tests++; if (pe !== 16'd1 || error_count !== 16'd2 || locked !== 1'b0) begin
          fails++; $display("FAIL miss_at_hss: got err %0d->%0d lk=%b want 1->2 lk=0", pe, error_count, locked);
        end
      end
    end
    tests++; if (!seen) begin fails++; $display("FAIL miss_seen: got 0 want 1"); end
    tests++; if (error_count !== 16'd2) begin fails++; $display("FAIL miss_errors: got %0d want 2", error_count); end
    wait_relock(bad, occ);
    tests++; if (bad != 0 || occ != 2) begin fails++; $display("FAIL miss_relock: got bad=%0d occ=%0d want 0,2", bad, occ); end
  endtask

  task automatic test_vs_delay();
    logic [15:0] e0;
    for (int i = 0; i < 200 && !(gx == 0 && gy == VSS); i++) cyc();
    e0 = error_count;
    vs_ovr = 1;
    repeat (5) cyc();
    vs_ovr = -1;
    repeat (4) cyc();
    tests++; if (error_count !== e0 + 16'd2) begin fails++; $display("FAIL vsdly_errors: got %0d want %0d", error_count, e0 + 16'd2); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL vsdly_locked: got %b want 0", locked); end
    repeat (2 * LINE + 1) cyc();
    tests++; if (error_count !== e0 + 16'd2) begin fails++; $display("FAIL vsdly_after: got %0d want %0d", error_count, e0 + 16'd2); end
  endtask

  task automatic test_mid_reset();
    int bad, occ;
    for (int i = 0; i < 200 && !(gx == 2 && gy == 1); i++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    tests++; if ({pixel_valid, frame_start, locked} !== 3'b000 || {r_out, g_out, b_out} !== 12'd0) begin
      fails++; $display("FAIL mid_rst_flags: got v=%b fs=%b lk=%b rgb=%h want 0", pixel_valid, frame_start, locked, {r_out, g_out, b_out});
    end
    tests++; if (error_count !== 16'd0 || frame_count !== 32'd0) begin fails++; $display("FAIL mid_rst_counts: got %0d,%0d want 0,0", error_count, frame_count); end
    wait_relock(bad, occ);
    tests++; if (bad != 0 || occ != 2) begin fails++; $display("FAIL mid_relock: got bad=%0d occ=%0d want 0,2", bad, occ); end
    tests++; if (error_count !== 16'd0) begin fails++; $display("FAIL mid_errors: got %0d want 0", error_count); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 65600; i++) begin
      hs_ovr = i % 2;
      vs_ovr = i % 2;
      cyc();
    end
    hs_ovr = -1; vs_ovr = -1;
    tests++; if (error_count !== 16'hFFFF) begin fails++; $display("FAIL sat_errors: got %0d want 65535", error_count); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL sat_locked: got %b want 0", locked); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_frames();
    test_hs_early();
    test_hs_missing();
    test_vs_delay();
    test_mid_reset();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
